// File: rtl/sraml_pkg.sv
// sraml_pkg: shared types for the SRAM-like bus arbiter.
// Holds the arbiter FSM state encoding, the bus-owner encoding and the
// transfer size codes used on the SRAM-like interface.
package sraml_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/sraml_arb_pick.sv
// sraml_arb_pick: combinational grant selection between the instruction and
// data masters. With SRAML_ARB_RR_EN defined, simultaneous requests alternate
// (the master not granted last wins); otherwise data always beats instruction.
module sraml_arb_pick
  import sraml_pkg::*;
(
  input  logic   inst_req,
  input  logic   data_req,
  input  owner_e last_grant,
  output logic   grant_valid,
  output owner_e grant_owner
);

`ifndef SRAML_ARB_RR_EN
  // Fixed priority never looks at the grant history.
  logic unused_last_grant_s;
  assign unused_last_grant_s = last_grant;
`endif

  // Pick a winner from the current requests.
  always_comb begin
    grant_valid = inst_req | data_req;
    grant_owner = OWN_DATA;
    if (inst_req && data_req) begin
`ifdef SRAML_ARB_RR_EN
      grant_owner = (last_grant == OWN_INST) ? OWN_DATA : OWN_INST;
`else
      grant_owner = OWN_DATA;
`endif
    end else if (inst_req) begin
      grant_owner = OWN_INST;
    end else begin
      grant_owner = OWN_DATA;
    end
  end

endmodule

// File: rtl/sraml_arbiter.sv
// sraml_arbiter: two-master (inst/data), one-slave SRAM-like bus arbiter.
// One transaction outstanding; the grant is held from request until the
// slave's data_ok, and data_ok is routed back only to the granted master.
// Optional build macro: SRAML_ARB_RR_EN (round-robin on simultaneous requests).
module sraml_arbiter
  import sraml_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic [31:0] inst_rdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic [31:0] rdata,
  input  logic        addr_ok,
  input  logic        data_ok
);

  state_e state_r;
  state_e state_nxt_s;
  owner_e owner_r;
  owner_e last_r;
  logic   pick_valid_s;
  owner_e pick_owner_s;
  owner_e sel_owner_s;
  logic   fwd_s;

  sraml_arb_pick u_pick (
    .inst_req    (inst_req),
    .data_req    (data_req),
    .last_grant  (last_r),
    .grant_valid (pick_valid_s),
    .grant_owner (pick_owner_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latch owner and grant history whenever a fresh grant is made in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_r <= OWN_DATA;
      last_r  <= OWN_INST;
    end else if ((state_r == ST_IDLE) && pick_valid_s) begin
      owner_r <= pick_owner_s;
      last_r  <= pick_owner_s;
    end
  end

  // Next-state logic: track address and data handshakes of the granted master.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s && addr_ok && data_ok) begin
          state_nxt_s = ST_IDLE;
        end else if (pick_valid_s && addr_ok) begin
          state_nxt_s = ST_DATA;
        end else if (pick_valid_s) begin
          state_nxt_s = ST_ADDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (addr_ok && data_ok) begin
          state_nxt_s = ST_IDLE;
        end else if (addr_ok) begin
          state_nxt_s = ST_DATA;
        end else begin
          state_nxt_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (data_ok) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DATA;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output logic: forward the granted master's request and route handshakes back.
  always_comb begin
    sel_owner_s  = (state_r == ST_IDLE) ? pick_owner_s : owner_r;
    fwd_s        = 1'b0;
    req          = 1'b0;
    wr           = 1'b0;
    size         = 2'd0;
    addr         = 32'd0;
    wdata        = 32'd0;
    inst_rdata   = rdata;
    data_rdata   = rdata;
    case (state_r)
      ST_IDLE: fwd_s = pick_valid_s;
      ST_ADDR: fwd_s = (owner_r == OWN_INST) ? inst_req : data_req;
      ST_DATA: fwd_s = 1'b0;
      default: fwd_s = 1'b0;
    endcase
    if (fwd_s && (sel_owner_s == OWN_INST)) begin
      req   = 1'b1;
      wr    = inst_wr;
      size  = inst_size;
      addr  = inst_addr;
      wdata = inst_wdata;
    end else if (fwd_s) begin
      req   = 1'b1;
      wr    = data_wr;
      size  = data_size;
      addr  = data_addr;
      wdata = data_wdata;
    end else begin
      req   = 1'b0;
    end
    inst_addr_ok = addr_ok & fwd_s & (sel_owner_s == OWN_INST);
    data_addr_ok = addr_ok & fwd_s & (sel_owner_s == OWN_DATA);
    // In IDLE only a same-cycle grant can own data_ok; a stray one is dropped.
    inst_data_ok = data_ok &
                   (((state_r != ST_IDLE) && (owner_r == OWN_INST)) ||
                    ((state_r == ST_IDLE) && pick_valid_s && (pick_owner_s == OWN_INST)));
    data_data_ok = data_ok &
                   (((state_r != ST_IDLE) && (owner_r == OWN_DATA)) ||
                    ((state_r == ST_IDLE) && pick_valid_s && (pick_owner_s == OWN_DATA)));
  end

endmodule

// File: tb/tb_sraml_arbiter.sv
// tb_sraml_arbiter: cycle-by-cycle vector table for sraml_arbiter. Each row
// drives one cycle of master/slave inputs; the expected slave fields and
// master handshakes are queued at drive time and checked mid-cycle.
module tb_sraml_arbiter;

  localparam logic [31:0] IA  = 32'hBFC0_0000;
  localparam logic [31:0] IWD = 32'h1111_2222;
  localparam logic [31:0] DA  = 32'h8000_0010;
  localparam logic [31:0] DW  = 32'hDEAD_BEEF;
  localparam logic [31:0] RD  = 32'h2408_0001;

  logic        clk;
  logic        rst;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic [31:0] inst_rdata, data_rdata, addr, wdata, rdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic        req, wr, addr_ok, data_ok;
  bit          done;

  typedef struct {
    string       name;
    bit          rst, ir, dr, dw, aok, dok;
    logic [31:0] rd;
    bit          e_req, e_who, e_iaok, e_daok, e_idok, e_ddok;
  } vec_t;

  vec_t         tbl[$];
  logic [135:0] exp_q[$];
  string        name_q[$];
  int           total;
  int           bad;

  sraml_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .rdata(rdata), .addr_ok(addr_ok), .data_ok(data_ok)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input string n, input bit r, input bit ir, input bit dr,
                              input bit dw, input bit aok, input bit dok,
                              input logic [31:0] rd, input bit e_req, input bit e_who,
                              input bit e_iaok, input bit e_daok,
                              input bit e_idok, input bit e_ddok);
    vec_t v;
    v.name = n; v.rst = r; v.ir = ir; v.dr = dr; v.dw = dw;
    v.aok = aok; v.dok = dok; v.rd = rd;
    v.e_req = e_req; v.e_who = e_who;
    v.e_iaok = e_iaok; v.e_daok = e_daok; v.e_idok = e_idok; v.e_ddok = e_ddok;
    return v;
  endfunction

  // Expected output vector: e_who=1 means the data master owns the slave fields.
  function automatic logic [135:0] exp_pack(input vec_t v);
    logic        w;
    logic [1:0]  s;
    logic [31:0] a, d;
    w = 1'b0; s = 2'd0; a = 32'd0; d = 32'd0;
    if (v.e_req && v.e_who) begin
      w = v.dw; s = 2'd2; a = DA; d = DW;
    end else if (v.e_req) begin
      w = 1'b0; s = 2'd2; a = IA; d = IWD;
    end
    return {v.e_req, w, s, a, d, v.e_iaok, v.e_daok, v.e_idok, v.e_ddok, v.rd, v.rd};
  endfunction

  // Watchdog: fail if the vector run does not complete in time.
  initial begin
    done = 1'b0;
    #100000;
    if (!done) begin
      $display("FAIL timeout: vector run did not complete");
      $finish;
    end
  end

  initial begin
    logic [135:0] act, e;
    string        n;
    bit           w0, w1, w2, w3;
    clk = 1'b0; rst = 1'b1; total = 0; bad = 0;
    inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = IA; inst_wdata = IWD;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd2; data_addr = DA; data_wdata = DW;
    rdata = 32'd0; addr_ok = 1'b0; data_ok = 1'b0;

`ifdef SRAML_ARB_RR_EN
    w0 = 1'b1; w1 = 1'b0; w2 = 1'b1; w3 = 1'b0;
`else
    w0 = 1'b1; w1 = 1'b1; w2 = 1'b1; w3 = 1'b1;
`endif

    //             name          rst ir dr dw aok dok rd            req who ia da id dd
    tbl.push_back(mk("reset",      1, 0, 0, 0, 0, 0, 32'd0,          0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("irdA0",      0, 1, 0, 0, 1, 0, 32'd0,          1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("irdA1",      0, 0, 0, 0, 0, 0, 32'd0,          0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("irdA2",      0, 0, 0, 0, 0, 1, RD,             0, 0, 0, 0, 1, 0));
    tbl.push_back(mk("stray_dok",  0, 0, 0, 0, 0, 1, 32'h0BAD_0BAD,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("sim0",       0, 1, 1, 1, 1, 0, 32'd0,          1, 1, 0, 1, 0, 0));
    tbl.push_back(mk("sim1",       0, 1, 0, 0, 0, 0, 32'd0,          0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("sim2",       0, 1, 0, 0, 0, 1, 32'h0000_00AA,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("sim3_1cyc",  0, 1, 0, 0, 1, 1, 32'h0000_00BB,  1, 0, 1, 0, 1, 0));
    tbl.push_back(mk("b2b",        0, 1, 0, 0, 1, 1, 32'h0000_00CC,  1, 0, 1, 0, 1, 0));
    tbl.push_back(mk("slow0",      0, 0, 1, 0, 0, 0, 32'd0,          1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("slow1",      0, 1, 1, 0, 0, 0, 32'd0,          1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("slow2",      0, 1, 1, 0, 0, 0, 32'd0,          1, 1, 0, 0, 0, 0));
    tbl.push_back(mk("slow3",      0, 1, 1, 0, 1, 0, 32'd0,          1, 1, 0, 1, 0, 0));
    tbl.push_back(mk("slow4",      0, 1, 0, 0, 0, 1, 32'h1234_5678,  0, 0, 0, 0, 0, 1));
    tbl.push_back(mk("slow5",      0, 1, 0, 0, 1, 0, 32'd0,          1, 0, 1, 0, 0, 0));
    tbl.push_back(mk("rstD0",      0, 0, 0, 0, 0, 0, 32'd0,          0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rstD1",      1, 0, 0, 0, 0, 0, 32'd0,          0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rstD2",      0, 0, 0, 0, 0, 1, 32'h0000_0077,  0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("rstD3",      0, 0, 1, 0, 1, 1, 32'h5555_AAAA,  1, 1, 0, 1, 0, 1));
    tbl.push_back(mk("rr_rst",     1, 0, 0, 0, 0, 0, 32'd0,          0, 0, 0, 0, 0, 0));
    tbl.push_back(mk("both0", 0, 1, 1, 1, 1, 1, 32'h0000_0010, 1, w0, !w0, w0, !w0, w0));
    tbl.push_back(mk("both1", 0, 1, 1, 1, 1, 1, 32'h0000_0011, 1, w1, !w1, w1, !w1, w1));
    tbl.push_back(mk("both2", 0, 1, 1, 1, 1, 1, 32'h0000_0012, 1, w2, !w2, w2, !w2, w2));
    tbl.push_back(mk("both3", 0, 1, 1, 1, 1, 1, 32'h0000_0013, 1, w3, !w3, w3, !w3, w3));
    tbl.push_back(mk("idle_end",   0, 0, 0, 0, 0, 0, 32'd0,          0, 0, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1;
      rst      = tbl[i].rst;
      inst_req = tbl[i].ir;
      data_req = tbl[i].dr;
      data_wr  = tbl[i].dw;
      addr_ok  = tbl[i].aok;
      data_ok  = tbl[i].dok;
      rdata    = tbl[i].rd;
      exp_q.push_back(exp_pack(tbl[i]));
      name_q.push_back(tbl[i].name);
      @(negedge clk);
      act = {req, wr, size, addr, wdata, inst_addr_ok, data_addr_ok,
             inst_data_ok, data_data_ok, inst_rdata, data_rdata};
      e = exp_q.pop_front();
      n = name_q.pop_front();
      total++;
      if (act !== e) begin
        bad++;
        $display("FAIL %s: got %h want %h", n, act, e);
      end
      if (tbl[i].rst) begin
        total++;
        if ({req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok} !== 5'b00000) begin
          bad++;
          $display("FAIL %s reset-state: req=%b iaok=%b daok=%b idok=%b ddok=%b",
                   n, req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok);
        end
      end
    end
    done = 1'b1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
